// File: rtl/fb_pkg.sv
// fb_pkg: shared widths, state encoding and address helpers for the frame-buffer scan master
package fb_pkg;
    localparam int ADDR_W    = 17;
    localparam int DATA_W    = 32;
    localparam int MEM_WORDS = 77500;

    localparam logic MODE_SCAN = 1'b0;
    localparam logic MODE_FILL = 1'b1;

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, FILL} state_t;

    function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
        return (a == ADDR_W'(MEM_WORDS - 1)) ? '0 : a + ADDR_W'(1);
    endfunction

    // 2^ADDR_W < 2*MEM_WORDS, so one subtraction is a full modulo reduction
    function automatic logic [ADDR_W-1:0] addr_mod(input logic [ADDR_W-1:0] a);
        return (a >= ADDR_W'(MEM_WORDS)) ? a - ADDR_W'(MEM_WORDS) : a;
    endfunction
endpackage

// File: rtl/fb_stream_fifo.sv
// fb_stream_fifo: show-ahead FIFO buffering captured read data towards the pixel stream
module fb_stream_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 32
) (
    input  logic                   clk_i,
    input  logic                   reset_n_i,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic [W-1:0]           data_i,
    output logic [W-1:0]           data_o,
    output logic                   empty_o,
    output logic                   full_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0]   count_q;
    logic          do_push, do_pop;

    assign count_o = count_q;
    assign empty_o = count_q == '0;
    assign full_o  = count_q == (AW+1)'(DEPTH);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign data_o  = empty_o ? '0 : mem_q[rd_q];

    // storage array, written only on push so it needs no reset
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_q] <= data_i;
    end

    // pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            wr_q    <= do_push ? wr_q + AW'(1) : wr_q;
            rd_q    <= do_pop ? rd_q + AW'(1) : rd_q;
            count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/fb_scan_master.sv
// fb_scan_master: Avalon-MM master that streams a frame-memory word range out (SCAN) or clears it to a constant (FILL)
module fb_scan_master
    import fb_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int RD_LAT     = 1
) (
    input  logic              clk_i,
    input  logic              reset_n_i,
    input  logic              start_i,
    input  logic              mode_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic [ADDR_W-1:0] num_words_i,
    input  logic [DATA_W-1:0] fill_data_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [ADDR_W-1:0] avm_address_o,
    output logic              avm_chipselect_o,
    output logic              avm_write_o,
    output logic [3:0]        avm_byteenable_o,
    output logic [DATA_W-1:0] avm_writedata_o,
    output logic              avm_clken_o,
    input  logic [DATA_W-1:0] avm_readdata_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic              out_valid_o,
    input  logic              out_ready_i
);
    localparam int CW = $clog2(FIFO_DEPTH) + 2;

    state_t                    state_q;
    logic [ADDR_W-1:0]         num_q, issued_q, addr_q;
    logic [DATA_W-1:0]         wdata_q;
    logic [3:0]                be_q;
    logic                      busy_q, done_q, cs_q, wr_q, clken_q;
    logic [RD_LAT-1:0]         vld_q, vld_d;
    logic [CW-1:0]             infl_d, occ_d;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    logic                      push, pop, empty, full, room, drained;

    assign busy_o           = busy_q;
    assign done_o           = done_q;
    assign avm_address_o    = addr_q;
    assign avm_chipselect_o = cs_q;
    assign avm_write_o      = wr_q;
    assign avm_byteenable_o = be_q;
    assign avm_writedata_o  = wdata_q;
    assign avm_clken_o      = clken_q;
    assign out_valid_o      = !empty;

    // a read on the bus this cycle enters the latency pipe at the next edge
    assign vld_d = RD_LAT'({vld_q, cs_q && !wr_q});
    assign push  = vld_q[RD_LAT-1];
    assign pop   = !empty && out_ready_i;
    assign occ_d = CW'(fifo_count) + CW'(push) - CW'(pop);

    // words already owed to the FIFO after this edge, used as read credit
    always_comb begin
        infl_d = '0;
        for (int i = 0; i < RD_LAT; i++) infl_d = infl_d + CW'(vld_d[i]);
    end

    assign room    = !full && (occ_d + infl_d < CW'(FIFO_DEPTH));
    assign drained = (vld_d == '0) && (occ_d == '0);

    fb_stream_fifo #(.DEPTH(FIFO_DEPTH), .W(DATA_W)) u_fifo (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .push_i    (push),
        .pop_i     (pop),
        .data_i    (avm_readdata_i),
        .data_o    (out_data_o),
        .empty_o   (empty),
        .full_o    (full),
        .count_o   (fifo_count)
    );

    // command FSM; the first access goes out on the accept edge so data appears two edges later
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q  <= IDLE;
            num_q    <= '0;
            issued_q <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            be_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            cs_q     <= 1'b0;
            wr_q     <= 1'b0;
            clken_q  <= 1'b0;
            vld_q    <= '0;
        end else begin
            clken_q <= 1'b1;
            done_q  <= 1'b0;
            vld_q   <= vld_d;
            case (state_q)
                IDLE: begin
                    cs_q <= 1'b0;
                    wr_q <= 1'b0;
                    be_q <= '0;
                    if (start_i && num_words_i == '0) begin
                        done_q <= 1'b1;
                    end else if (start_i) begin
                        num_q    <= num_words_i;
                        issued_q <= ADDR_W'(1);
                        addr_q   <= addr_mod(base_addr_i);
                        wdata_q  <= fill_data_i;
                        cs_q     <= 1'b1;
                        wr_q     <= mode_i == MODE_FILL;
                        be_q     <= 4'hF;
                        busy_q   <= 1'b1;
                        state_q  <= (mode_i == MODE_FILL) ? FILL : SCAN;
                    end
                end
                SCAN, FILL: begin
                    if (issued_q == num_q) begin
                        cs_q    <= 1'b0;
                        wr_q    <= 1'b0;
                        be_q    <= '0;
                        done_q  <= state_q == FILL;
                        busy_q  <= state_q == SCAN;
                        state_q <= (state_q == FILL) ? IDLE : DRAIN;
                    end else if (state_q == FILL || room) begin
                        cs_q     <= 1'b1;
                        be_q     <= 4'hF;
                        addr_q   <= addr_inc(addr_q);
                        issued_q <= issued_q + ADDR_W'(1);
                    end else begin
                        cs_q <= 1'b0;
                        be_q <= '0;
                    end
                end
                DRAIN: begin
                    if (drained) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fb_scan_master.sv
// tb_fb_scan_master: table-driven scoreboard bench for the frame-buffer scan master
module tb_fb_scan_master;
    localparam int MW = 77500;

    typedef struct {
        logic        mode;
        logic [16:0] base;
        logic [16:0] num;
        logic [31:0] fill;
        int          stall;
        bit          poke;
        logic [16:0] first;
        int          lat;
    } vec_t;

    typedef struct {
        logic [16:0] addr;
        logic        wr;
        logic [31:0] data;
    } acc_t;

    logic        clk = 0, reset_n = 0, start = 0, mode = 0, out_ready = 1;
    logic [16:0] base_addr = 0, num_words = 0;
    logic [31:0] fill_data = 0, rdata = 0;
    logic        busy, done, avm_cs, avm_wr, avm_clken, out_valid;
    logic [16:0] avm_addr;
    logic [3:0]  avm_be;
    logic [31:0] avm_wdata, out_data;

    logic [31:0] smem [MW];
    logic [31:0] ref_mem [MW];
    acc_t        exp_acc [$];
    logic [31:0] exp_data [$];
    acc_t        mon_e;
    vec_t        tbl [7];
    int          n_pass = 0, n_total = 0, ops = 0, hs = 0, cyc = 0, first_v = 0;
    bit          seen_v = 0;

    fb_scan_master dut (
        .clk_i            (clk),
        .reset_n_i        (reset_n),
        .start_i          (start),
        .mode_i           (mode),
        .base_addr_i      (base_addr),
        .num_words_i      (num_words),
        .fill_data_i      (fill_data),
        .busy_o           (busy),
        .done_o           (done),
        .avm_address_o    (avm_addr),
        .avm_chipselect_o (avm_cs),
        .avm_write_o      (avm_wr),
        .avm_byteenable_o (avm_be),
        .avm_writedata_o  (avm_wdata),
        .avm_clken_o      (avm_clken),
        .avm_readdata_i   (rdata),
        .out_data_o       (out_data),
        .out_valid_o      (out_valid),
        .out_ready_i      (out_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // frame memory slave with read latency 1
    always @(posedge clk) begin
        if (avm_cs && avm_wr) smem[avm_addr] <= avm_wdata;
        else if (avm_cs) rdata <= smem[avm_addr];
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // bus and stream monitor: pops the scoreboard on every access and handshake
    always @(negedge clk) begin
        if (reset_n) begin
            if (avm_cs) begin
                ops++;
                if (exp_acc.size() == 0) begin
                    n_total++;
                    $display("FAIL extra_access: got addr %0d expected no access", avm_addr);
                end else begin
                    mon_e = exp_acc.pop_front();
                    chk("acc_addr", 64'(avm_addr), 64'(mon_e.addr));
                    chk("acc_write", 64'(avm_wr), 64'(mon_e.wr));
                    chk("acc_be", 64'(avm_be), 64'hF);
                    if (mon_e.wr) chk("acc_wdata", 64'(avm_wdata), 64'(mon_e.data));
                end
            end
            if (out_valid && !seen_v) begin
                seen_v  = 1;
                first_v = cyc;
            end
            if (out_valid && out_ready) begin
                hs++;
                if (exp_data.size() == 0) begin
                    n_total++;
                    $display("FAIL extra_word: got %0h expected no word", out_data);
                end else chk("out_data", 64'(out_data), 64'(exp_data.pop_front()));
            end
        end
    end

    task automatic check_reset();
        chk("rst_busy", 64'(busy), 0);
        chk("rst_done", 64'(done), 0);
        chk("rst_cs", 64'(avm_cs), 0);
        chk("rst_wr", 64'(avm_wr), 0);
        chk("rst_addr", 64'(avm_addr), 0);
        chk("rst_be", 64'(avm_be), 0);
        chk("rst_wdata", 64'(avm_wdata), 0);
        chk("rst_clken", 64'(avm_clken), 0);
        chk("rst_valid", 64'(out_valid), 0);
        chk("rst_data", 64'(out_data), 0);
    endtask

    task automatic run_cmd(input vec_t v);
        int          c0;
        bit          got;
        logic [16:0] a;
        ops = 0;
        hs = 0;
        seen_v = 0;
        for (int i = 0; i < int'(v.num); i++) begin
            a = 17'((int'(v.first) + i) % MW);
            exp_acc.push_back('{a, v.mode, v.fill});
            if (v.mode) ref_mem[a] = v.fill;
            else exp_data.push_back(ref_mem[a]);
        end
        out_ready = (v.stall == 0);
        @(posedge clk); #1;
        start = 1; mode = v.mode; base_addr = v.base; num_words = v.num; fill_data = v.fill;
        @(posedge clk); #1;
        start = 0;
        c0 = cyc;
        chk("busy_after_start", 64'(busy), 1);
        got = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (v.poke && i == 3) begin
                start = 1; mode = ~v.mode; base_addr = 17'd0; num_words = 17'd3; fill_data = 32'hBAD0BAD0;
            end
            if (v.poke && i == 4) start = 0;
            if (v.stall != 0 && i == v.stall - 1) begin
                chk("stall_reads", 64'(ops), 8);
                chk("stall_cs_low", 64'(avm_cs), 0);
                chk("stall_no_word", 64'(hs), 0);
                out_ready = 1;
            end
            if (done) begin
                got = 1;
                if (v.lat != 0) chk("done_latency", 64'(cyc - c0), 64'(v.lat));
                chk("busy_with_done", 64'(busy), 0);
                break;
            end
        end
        if (!got) begin
            n_total++;
            $display("FAIL done_timeout: got no done expected done within 3000 cycles");
        end
        chk("access_count", 64'(ops), 64'(v.num));
        chk("acc_left", 64'(exp_acc.size()), 0);
        chk("data_left", 64'(exp_data.size()), 0);
        if (!v.mode) chk("first_valid_lat", 64'(first_v - c0), 2);
        @(negedge clk);
        chk("done_one_cycle", 64'(done), 0);
    endtask

    initial begin
        for (int i = 0; i < MW; i++) begin
            smem[i] = 32'(i);
            ref_mem[i] = 32'(i);
        end
        tbl[0] = '{1'b0, 17'h10,    17'd16, 32'h0,        0,  1'b0, 17'h10,    18};
        tbl[1] = '{1'b0, 17'd77498, 17'd4,  32'h0,        0,  1'b0, 17'd77498, 6};
        tbl[2] = '{1'b0, 17'h200,   17'd32, 32'h0,        20, 1'b0, 17'h200,   0};
        tbl[3] = '{1'b1, 17'd100,   17'd5,  32'hDEADBEEF, 0,  1'b0, 17'd100,   5};
        tbl[4] = '{1'b0, 17'd100,   17'd5,  32'h0,        0,  1'b0, 17'd100,   7};
        tbl[5] = '{1'b0, 17'd77503, 17'd3,  32'h0,        0,  1'b0, 17'd3,     5};
        tbl[6] = '{1'b0, 17'h40,    17'd8,  32'h0,        0,  1'b1, 17'h40,    10};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset();
        @(posedge clk); #1;
        reset_n = 1;
        @(posedge clk); #1;
        chk("clken_after_reset", 64'(avm_clken), 1);
        chk("idle_busy", 64'(busy), 0);

        for (int i = 0; i < 7; i++) run_cmd(tbl[i]);

        ops = 0;
        @(posedge clk); #1;
        start = 1; mode = 0; base_addr = 17'd5; num_words = 17'd0;
        @(posedge clk); #1;
        start = 0;
        chk("zero_done", 64'(done), 1);
        chk("zero_busy", 64'(busy), 0);
        chk("zero_cs", 64'(avm_cs), 0);
        @(posedge clk); #1;
        chk("zero_done_clear", 64'(done), 0);
        chk("zero_no_access", 64'(ops), 0);

        ops = 0;
        hs = 0;
        out_ready = 1;
        for (int i = 0; i < 16; i++) begin
            exp_acc.push_back('{17'(768 + i), 1'b0, 32'h0});
            exp_data.push_back(ref_mem[768 + i]);
        end
        @(posedge clk); #1;
        start = 1; mode = 0; base_addr = 17'd768; num_words = 17'd16;
        @(posedge clk); #1;
        start = 0;
        for (int i = 0; i < 100 && hs < 3; i++) @(posedge clk);
        #1;
        chk("words_before_reset", 64'(hs), 3);
        reset_n = 0;
        #1;
        check_reset();
        exp_acc.delete();
        exp_data.delete();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1;
        run_cmd(tbl[0]);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/fb_scan_master.md
Name: fb_scan_master

Overview:
- Avalon-MM master for the 32-bit single-port on-chip frame memory slave: 17-bit word address, fixed read latency 1, byteenable, clken.
- SCAN mode reads a contiguous word range and streams it through a valid/ready output to the pixel/VGA pipeline.
- FILL mode writes one constant word over a range, e.g. to clear the screen.
- Sits between the frame memory's second slave port and the display logic.

Parameters:
- ADDR_W, 17, word address width.
- DATA_W, 32, data width.
- MEM_WORDS, 77500, memory depth; addresses wrap modulo this value.
- FIFO_DEPTH, 8, output buffer depth; power of 2, at least 4.
- RD_LAT, 1, fixed slave read latency in cycles.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle command strobe; honoured only when busy=0.
- mode  in  1  0=SCAN, 1=FILL; sampled with start.
- base_addr  in  17  first word address; sampled with start.
- num_words  in  17  transfer length in words; sampled with start.
- fill_data  in  32  FILL value; sampled with start.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle completion pulse.
- avm_address  out  17  word address to the memory.
- avm_chipselect  out  1  access strobe.
- avm_write  out  1  write qualifier.
- avm_byteenable  out  4  always 4'hF while chipselect is high.
- avm_writedata  out  32  equals fill_data during FILL.
- avm_clken  out  1  memory clock enable.
- avm_readdata  in  32  read data, valid RD_LAT cycles after the read.
- out_data  out  32  streamed word.
- out_valid  out  1  out_data valid.
- out_ready  in  1  consumer accept; a word transfers when out_valid and out_ready are both high.

Behaviour:
- Reset values: busy=0, done=0, avm_chipselect=0, avm_write=0, avm_address=0, avm_byteenable=0, avm_writedata=0, avm_clken=0, out_valid=0, out_data=0. Reset also empties the FIFO, clears all counters and sets state=IDLE. avm_clken becomes 1 on the first edge after reset deasserts and stays 1.
- All avm_* outputs are registered.
- States: IDLE, SCAN, DRAIN, FILL.
  - IDLE: start=1 latches the inputs. num_words=0 gives done=1 on the next cycle, stays IDLE and performs no bus access. Otherwise go to SCAN or FILL.
  - SCAN: issue one read per cycle (chipselect=1, write=0) while issued<num_words and fifo_count+inflight<FIFO_DEPTH. Otherwise drop chipselect (bubble). Go to DRAIN after the last read is issued.
  - DRAIN: wait until inflight=0 and the FIFO is empty after the last handshake. Then done=1 and return to IDLE.
  - FILL: one write per cycle (chipselect=1, write=1), no stalls. done pulses in the cycle after the last write, then IDLE.
- Address: starts at base_addr and increments by 1 per access. MEM_WORDS-1 is followed by 0. base_addr>=MEM_WORDS is reduced modulo MEM_WORDS when latched.
- Read capture: avm_readdata is pushed into the FIFO exactly RD_LAT cycles after each read cycle. A RD_LAT-deep valid shift register tracks in-flight reads; inflight is its popcount.
- Credit rule: the FIFO never overflows and a captured word is never dropped.
- FIFO is show-ahead: out_valid = !empty and out_data = head entry.
- Latency: start accepted at edge E0 gives the first read on the bus after E0, capture at E2, and out_valid=1 after E2. With out_ready held at 1 and no stalls, SCAN sustains one word per cycle.
- start while busy=1 is ignored; latched parameters do not change.
- out_ready held low: reads stop once fifo_count+inflight=FIFO_DEPTH. Resuming loses and duplicates nothing.
- Output order equals address order.
- Reset mid-operation: immediate return to reset values. Data in flight is discarded and no done pulse is produced.
- done and busy: done=1 coincides with busy falling to 0.

Decomposition:
- Shared package fb_pkg: ADDR_W, DATA_W, MEM_WORDS, state enum (IDLE/SCAN/DRAIN/FILL), MODE_SCAN/MODE_FILL constants.
- One sub-module, fb_stream_fifo: synchronous show-ahead FIFO with push, pop, data_in, data_out, empty, full and count. It resets asynchronously on reset_n.

Test Plan:
- SCAN, base=0x00010, num=16, out_ready=1, memory word i = i -> out_data 0x10..0x1F consecutive, first out_valid 2 cycles after the start edge, done after the 16th handshake, 16 reads issued.
- SCAN, base=77498, num=4 -> read addresses 77498, 77499, 0, 1; out_data in that order.
- SCAN, num=32, out_ready=0 for 20 cycles then 1 -> chipselect ceases once fifo_count+inflight=8, no overflow, all 32 words delivered in order.
- FILL, base=100, num=5, fill_data=32'hDEADBEEF -> 5 consecutive writes to 100..104 with byteenable=4'hF, done on the following cycle; a readback SCAN returns 5×DEADBEEF.
- start with num=0 -> done=1 next cycle, no chipselect; start pulsed while busy -> ignored and latched parameters unchanged.
- reset_n low mid-SCAN after 3 words -> all outputs return to reset values and the FIFO is empty; a new SCAN after release completes correctly.
